// File: rtl/pc_sequencer.sv
// PC sequencer for the accumulator processor: picks PCIn/PCWrite each cycle and keeps call/return and halt state.
// Define PC_RET_STACK_EN to replace the single link register with a STACK_DEPTH-entry return stack.
module pc_sequencer #(
    parameter int                 WIDTH        = 16,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                 INC          = 2,
    parameter int                 STACK_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pc_cur,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic [2:0]       op_type,
    input  logic             cond,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_write,
    output logic [1:0]       state,
    output logic             halted,
    output logic             illegal_op,
    output logic             stack_err
);

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [2:0] OP_SEQ    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    if (STACK_DEPTH < 2) begin : g_depth_check
        $error("pc_sequencer: STACK_DEPTH must be at least 2");
    end

    state_t           state_q;
    logic             illegal_q;
    logic             stack_err_q;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ret_addr;
    logic             exec_go;

    assign pc_inc  = pc_cur + WIDTH'(INC);
    assign exec_go = (state_q == S_EXEC) && !stall;

`ifdef PC_RET_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_m1;
    logic             stack_full;
    logic             stack_empty;

    assign sp_m1       = sp_q - SP_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    // An empty pop falls through to the next sequential instruction.
    assign ret_addr    = stack_empty ? pc_inc : stack_q[sp_m1[IDX_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (exec_go && op_type == OP_CALL) begin
            if (stack_full) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    stack_q[i] <= stack_q[i+1];
                end
                stack_q[STACK_DEPTH-1] <= pc_inc;
            end else begin
                stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
                sp_q <= sp_q + SP_W'(1);
            end
        end else if (exec_go && op_type == OP_RET && !stack_empty) begin
            sp_q <= sp_m1;
        end
    end

    logic stack_err_d;
    assign stack_err_d = exec_go && ((op_type == OP_CALL && stack_full) ||
                                     (op_type == OP_RET && stack_empty));
`else
    logic [WIDTH-1:0] link_q;

    assign ret_addr = link_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            link_q <= '0;
        end else if (exec_go && op_type == OP_CALL) begin
            link_q <= pc_inc;
        end
    end

    logic stack_err_d;
    assign stack_err_d = 1'b0;
`endif

    // PCIn/PCWrite are combinational so the PC register captures on the same edge.
    always_comb begin
        pc_next  = pc_inc;
        pc_write = 1'b0;
        if (!reset) begin
            pc_next = RESET_VECTOR;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    pc_next  = RESET_VECTOR;
                    pc_write = start;
                end
                S_FETCH: begin
                    pc_write = 1'b0;
                end
                S_EXEC: begin
                    if (!stall) begin
                        case (op_type)
                            OP_SEQ:    pc_write = 1'b1;
                            OP_BRANCH: begin
                                pc_next  = cond ? target : pc_inc;
                                pc_write = 1'b1;
                            end
                            OP_JUMP, OP_CALL: begin
                                pc_next  = target;
                                pc_write = 1'b1;
                            end
                            OP_RET: begin
                                pc_next  = ret_addr;
                                pc_write = 1'b1;
                            end
                            OP_HALT:   pc_write = 1'b0;
                            default:   pc_write = 1'b1;
                        endcase
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc_next  = RESET_VECTOR;
                        pc_write = 1'b1;
                    end
                end
                default: pc_write = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_INIT;
            illegal_q   <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            illegal_q   <= 1'b0;
            stack_err_q <= stack_err_d;
            case (state_q)
                S_INIT:  if (start) state_q <= S_FETCH;
                S_FETCH: if (instr_valid && !stall) state_q <= S_EXEC;
                S_EXEC: begin
                    if (!stall) begin
                        state_q   <= (op_type == OP_HALT) ? S_HALT : S_FETCH;
                        illegal_q <= (op_type > OP_HALT);
                    end
                end
                S_HALT:  if (start) state_q <= S_FETCH;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_q;
    assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random stimulus, all checked against a queue-based reference model.
module tb_pc_sequencer;

    localparam logic [15:0] RV    = 16'h0000;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] pc_cur;
    logic        instr_valid;
    logic        stall;
    logic [2:0]  op_type;
    logic        cond;
    logic [15:0] target;
    logic [15:0] pc_next;
    logic        pc_write;
    logic [1:0]  state;
    logic        halted;
    logic        illegal_op;
    logic        stack_err;

    pc_sequencer #(
        .WIDTH(16), .RESET_VECTOR(RV), .INC(2), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc_cur(pc_cur),
        .instr_valid(instr_valid), .stall(stall), .op_type(op_type),
        .cond(cond), .target(target), .pc_next(pc_next), .pc_write(pc_write),
        .state(state), .halted(halted), .illegal_op(illegal_op), .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle,1=fetch,2=execute,3=halted; return addresses in a queue.
    int          m_st;
    logic [15:0] m_link;
    logic [15:0] m_stk[$];
    logic        m_ill;
    logic        m_serr;

    function automatic void model_reset();
        m_st   = 0;
        m_link = 16'h0000;
        m_stk.delete();
        m_ill  = 1'b0;
        m_serr = 1'b0;
    endfunction

    function automatic void model_comb(output logic w, output logic [15:0] nx);
        logic [15:0] inc;
        inc = pc_cur + 16'd2;
        w   = 1'b0;
        nx  = inc;
        if (!reset) begin
            nx = RV;
        end else if (m_st == 0) begin
            nx = RV;
            w  = start;
        end else if (m_st == 3) begin
            if (start) begin
                w  = 1'b1;
                nx = RV;
            end
        end else if (m_st == 2 && !stall) begin
            w = 1'b1;
            case (op_type)
                3'd1: nx = cond ? target : inc;
                3'd2, 3'd3: nx = target;
                3'd4: begin
`ifdef PC_RET_STACK_EN
                    nx = (m_stk.size() == 0) ? inc : m_stk[$];
`else
                    nx = m_link;
`endif
                end
                3'd5: w = 1'b0;
                default: nx = inc;
            endcase
        end
    endfunction

    function automatic void model_edge();
        logic [15:0] inc;
        inc = pc_cur + 16'd2;
        if (!reset) begin
            model_reset();
            return;
        end
        m_ill  = 1'b0;
        m_serr = 1'b0;
        case (m_st)
            0: if (start) m_st = 1;
            1: if (instr_valid && !stall) m_st = 2;
            2: if (!stall) begin
                m_st  = (op_type == 3'd5) ? 3 : 1;
                m_ill = (op_type >= 3'd6);
                if (op_type == 3'd3) begin
`ifdef PC_RET_STACK_EN
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_front());
                        m_serr = 1'b1;
                    end
                    m_stk.push_back(inc);
`else
                    m_link = inc;
`endif
                end
`ifdef PC_RET_STACK_EN
                if (op_type == 3'd4) begin
                    if (m_stk.size() == 0) m_serr = 1'b1;
                    else void'(m_stk.pop_back());
                end
`endif
            end
            default: if (start) m_st = 1;
        endcase
    endfunction

    task automatic settle();
        logic        w;
        logic [15:0] nx;
        #4;
        if (!reset) model_reset();
        model_comb(w, nx);
        chk("state", {30'd0, state}, m_st);
        chk("pc_write", pc_write, w);
        if (w || m_st == 0) chk("pc_next", pc_next, nx);
        chk("halted", halted, (m_st == 3));
        chk("illegal_op", illegal_op, m_ill);
        chk("stack_err", stack_err, m_serr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // From FETCH: enter EXEC, present one op, settle; caller checks then ticks.
    task automatic exec_op(input logic [2:0] op, input logic c, input logic [15:0] tgt,
                           input logic [15:0] pc);
        instr_valid = 1'b1;
        stall       = 1'b0;
        op_type     = 3'd0;
        settle();
        tick();
        op_type = op;
        cond    = c;
        target  = tgt;
        pc_cur  = pc;
        settle();
        instr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pc_cur = '0; instr_valid = 1'b0;
        stall = 1'b0; op_type = '0; cond = 1'b0; target = '0;
        model_reset();
        @(posedge clk); #1;
        settle();
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_wr", pc_write, 0);
        tick();

        reset = 1'b1; start = 1'b1;
        settle();
        chk("init_wr", pc_write, 1);
        chk("init_next", pc_next, 16'h0000);
        tick();
        start = 1'b0;
        settle();
        chk("fetch_state", {30'd0, state}, 1);
        tick();

        exec_op(3'd0, 1'b0, 16'h0000, 16'h0000);
        chk("seq_next", pc_next, 16'h0002);
        tick();
        exec_op(3'd1, 1'b1, 16'h0040, 16'h0010);
        chk("br_taken", pc_next, 16'h0040);
        tick();
        exec_op(3'd1, 1'b0, 16'h0040, 16'h0010);
        chk("br_not", pc_next, 16'h0012);
        tick();
        exec_op(3'd3, 1'b0, 16'h0100, 16'h0020);
        chk("call_next", pc_next, 16'h0100);
        tick();
        exec_op(3'd4, 1'b0, 16'h0000, 16'h0104);
        chk("ret_next", pc_next, 16'h0022);
        tick();

`ifdef PC_RET_STACK_EN
        for (int i = 0; i < 5; i++) begin
            exec_op(3'd3, 1'b0, 16'h0200 + 16'(i * 16), 16'h0040 + 16'(i * 4));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            exec_op(3'd4, 1'b0, 16'h0000, 16'h0300);
            tick();
        end
`endif

        instr_valid = 1'b1;
        settle();
        tick();
        instr_valid = 1'b0; stall = 1'b1; op_type = 3'd0; pc_cur = 16'h0050;
        repeat (3) begin
            settle();
            chk("stall_wr", pc_write, 0);
            chk("stall_state", {30'd0, state}, 2);
            tick();
        end
        stall = 1'b0;
        settle();
        chk("release_wr", pc_write, 1);
        tick();
        settle();
        chk("after_release_wr", pc_write, 0);
        tick();

        exec_op(3'd0, 1'b0, 16'h0000, 16'hFFFE);
        chk("wrap_next", pc_next, 16'h0000);
        tick();
        exec_op(3'd7, 1'b0, 16'h0000, 16'h0030);
        chk("ill_next", pc_next, 16'h0032);
        tick();
        settle();
        chk("ill_pulse", illegal_op, 1);
        tick();
        settle();
        chk("ill_gone", illegal_op, 0);
        tick();

        exec_op(3'd5, 1'b0, 16'h0000, 16'h0060);
        chk("halt_wr", pc_write, 0);
        tick();
        settle();
        chk("halted", halted, 1);
        tick();
        start = 1'b1;
        settle();
        chk("restart_wr", pc_write, 1);
        chk("restart_next", pc_next, RV);
        tick();
        start = 1'b0;

        instr_valid = 1'b1;
        settle();
        tick();
        instr_valid = 1'b0; op_type = 3'd0; stall = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_state", {30'd0, state}, 0);
        chk("async_rst_wr", pc_write, 0);
        settle();
        tick();
        reset = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            reset       = ($urandom_range(0, 199) != 0);
            start       = ($urandom_range(0, 15) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            op_type     = 3'($urandom_range(0, 7));
            cond        = 1'($urandom_range(0, 1));
            target      = 16'($urandom);
            pc_cur      = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the PC register of the accumulator processor.
- Each cycle it decides whether the PC is written and with which value: sequential increment, conditional branch, jump, call or return.
- Sits between the control unit/decoder and the PC register. Drives that register's PCIn and PCWrite inputs and reads back its PCOut.
- Holds the call/return link state and a halt state.

Parameters:
- WIDTH, 16, PC width in bits.
- RESET_VECTOR, 16'h0000, first PC loaded on start.
- INC, 2, sequential increment (byte-addressed 16-bit instructions).
- STACK_DEPTH, 4, return-stack entries (used only with PC_RET_STACK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin or restart execution from RESET_VECTOR.
- pc_cur  in  WIDTH  current PC (PC register output).
- instr_valid  in  1  fetched instruction is available.
- stall  in  1  hold the PC this cycle.
- op_type  in  3  0=seq, 1=branch, 2=jump, 3=call, 4=return, 5=halt, 6/7=illegal.
- cond  in  1  branch condition (for op 1).
- target  in  WIDTH  branch/jump/call destination.
- pc_next  out  WIDTH  PCIn for the PC register.
- pc_write  out  1  PCWrite for the PC register.
- state  out  2  00=INIT, 01=FETCH, 10=EXEC, 11=HALT.
- halted  out  1  high while in HALT.
- illegal_op  out  1  one-cycle pulse on an illegal op_type in EXEC.
- stack_err  out  1  one-cycle pulse on return-stack overflow/underflow.

Behaviour:
- Reset (reset=0, async):
  - state=INIT, link register/stack cleared to 0, stack pointer 0.
  - pc_write=0, pc_next=RESET_VECTOR, halted=0, illegal_op=0, stack_err=0.
- pc_write and pc_next are combinational from state and inputs. The PC register captures on the same rising edge, so PCOut shows the new value 1 cycle after pc_write is sampled high.
- illegal_op and stack_err are registered pulses, high for the 1 cycle after the offending EXEC edge.
- INIT:
  - pc_next=RESET_VECTOR.
  - If start=1: pc_write=1, go to FETCH. Otherwise stay, pc_write=0.
- FETCH:
  - pc_write=0.
  - instr_valid=1 and stall=0 -> EXEC; otherwise stay.
  - start is ignored.
- EXEC with stall=1: stay in EXEC, pc_write=0, no link/stack update.
- EXEC with stall=0, then next state FETCH unless stated:
  - seq: pc_next=pc_cur+INC, pc_write=1.
  - branch: pc_next = cond ? target : pc_cur+INC, pc_write=1.
  - jump: pc_next=target, pc_write=1.
  - call: pc_next=target, pc_write=1, link <= pc_cur+INC.
  - return: pc_next=link, pc_write=1.
  - halt: pc_write=0, go to HALT.
  - 6/7: treated as seq, illegal_op pulse.
- HALT:
  - halted=1, pc_write=0.
  - start=1 -> behaves as INIT with start: pc_write=1 with RESET_VECTOR, go to FETCH, link preserved.
- Arithmetic: all adds are modulo 2^WIDTH. 16'hFFFE+2 wraps to 16'h0000 with no flag.
- Reset mid-operation: takes effect immediately, whatever the state or stall. A pending write is dropped (pc_write drops to 0 asynchronously).

Optional Feature:
- Macro: PC_RET_STACK_EN.
- Defined:
  - Link register replaced by a STACK_DEPTH-entry LIFO.
  - Call pushes pc_cur+INC; return pops to pc_next.
  - Call when full: push anyway, oldest entry dropped, stack_err pulse, jump still taken.
  - Return when empty: pc_next=pc_cur+INC, stack_err pulse.
- Undefined:
  - Single link register; call overwrites it (nested calls lose the outer return address).
  - stack_err tied to 0.

Test Plan:
- Reset low then high, start=1 for 1 cycle -> pc_write=1 with pc_next=16'h0000, state goes INIT->FETCH. With pc_cur=0 and op seq -> pc_write=1, pc_next=16'h0002.
- pc_cur=16'h0010, branch, target=16'h0040: cond=1 -> pc_next=16'h0040; cond=0 -> pc_next=16'h0012.
- pc_cur=16'h0020, call target=16'h0100, then return from pc_cur=16'h0104 -> pc_next=16'h0022. Under PC_RET_STACK_EN: 5 nested calls then 5 returns -> stack_err on the 5th call and the 5th return.
- EXEC with stall=1 for 3 cycles -> pc_write=0 and state=10 throughout. Release -> exactly one pc_write pulse.
- pc_cur=16'hFFFE, seq -> pc_next=16'h0000. op_type=7 -> seq result plus an illegal_op pulse of 1 cycle.
- halt in EXEC -> halted=1, no pc_write while start=0. Assert reset low mid-EXEC -> state=00 immediately, pc_write=0.
